// File: rtl/dca_matrix_lsu_wdata_packer.sv
// dca_matrix_lsu_wdata_packer: packs masked tensor rows into AXI W beats, one burst per descriptor.
module dca_matrix_lsu_wdata_packer #(
  parameter int MATRIX_NUM_COL = 4,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter int BW_LSU_ELEMENT = 32,
  localparam int BW_TENSOR_ROW = MATRIX_NUM_COL*BW_TENSOR_SCALAR,
  localparam int BW_LSU_ELEMENT_ROW = MATRIX_NUM_COL*BW_LSU_ELEMENT,
  localparam int BW_WSTRB = BW_LSU_ELEMENT_ROW/8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          txn_valid,
  output logic                          txn_ready,
  input  logic [7:0]                    txn_alen,
  input  logic [MATRIX_NUM_COL-1:0]     txn_col_mask,
  input  logic                          txn_is_last,
  input  logic                          tensor_valid,
  output logic                          tensor_ready,
  input  logic [BW_TENSOR_ROW-1:0]      tensor_row,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [BW_LSU_ELEMENT_ROW-1:0] wdata,
  output logic [BW_WSTRB-1:0]           wstrb,
  output logic                          wlast,
  output logic                          done
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_state_nxt;
  logic [7:0] r_alen, r_beat_cnt;
  logic [MATRIX_NUM_COL-1:0] r_mask;
  logic r_is_last, r_pending_done;
  logic w_txn_hs, w_row_hs, w_last_beat;
  logic [BW_LSU_ELEMENT_ROW-1:0] w_wdata;
  logic [BW_WSTRB-1:0] w_wstrb;
  assign w_txn_hs = txn_valid & txn_ready;
  assign w_row_hs = tensor_valid & tensor_ready;
  assign w_last_beat = r_beat_cnt == r_alen;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = (r_state == IDLE) ? (w_txn_hs ? BURST : IDLE)
                                    : ((w_row_hs & w_last_beat) ? IDLE : BURST);
  // the single output slot frees up in the same cycle it drains, so rows stream without bubbles
  always_comb begin
    txn_ready = r_state == IDLE;
    tensor_ready = (r_state == BURST) & (~wvalid | wready);
  end
  always_comb begin
    w_wdata = '0;
    w_wstrb = '0;
    for (int i = 0; i < MATRIX_NUM_COL; i++) begin
      w_wdata[i*BW_LSU_ELEMENT +: BW_LSU_ELEMENT] = r_mask[i] ? tensor_row[i*BW_TENSOR_SCALAR +: BW_LSU_ELEMENT] : '0;
      w_wstrb[i*(BW_LSU_ELEMENT/8) +: BW_LSU_ELEMENT/8] = {(BW_LSU_ELEMENT/8){r_mask[i]}};
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_alen <= '0;
      r_mask <= '0;
      r_is_last <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_txn_hs) begin
      r_alen <= txn_alen;
      r_mask <= txn_col_mask;
      r_is_last <= txn_is_last;
      r_beat_cnt <= '0;
    end else if (w_row_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
  always_ff @(posedge clk)
    if (rst) begin
      wvalid <= 1'b0;
      wdata <= '0;
      wstrb <= '0;
      wlast <= 1'b0;
      r_pending_done <= 1'b0;
      done <= 1'b0;
    end else begin
      if (w_row_hs) begin
        wvalid <= 1'b1;
        wdata <= w_wdata;
        wstrb <= w_wstrb;
        wlast <= w_last_beat;
        r_pending_done <= w_last_beat & r_is_last;
      end else if (wready) wvalid <= 1'b0;
      done <= wvalid & wready & r_pending_done;
    end
endmodule

// File: tb/tb_dca_matrix_lsu_wdata_packer.sv
// tb_dca_matrix_lsu_wdata_packer: directed checks of beat packing, stalls, burst chaining, done and reset abort.
module tb_dca_matrix_lsu_wdata_packer;
  logic clk = 1'b0;
  logic rst, txn_valid, txn_ready, txn_is_last, tensor_valid, tensor_ready;
  logic wvalid, wready, wlast, done;
  logic [7:0] txn_alen;
  logic [3:0] txn_col_mask;
  logic [127:0] tensor_row, wdata;
  logic [15:0] wstrb;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  dca_matrix_lsu_wdata_packer dut (
    .clk(clk), .rst(rst),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_alen(txn_alen),
    .txn_col_mask(txn_col_mask), .txn_is_last(txn_is_last),
    .tensor_valid(tensor_valid), .tensor_ready(tensor_ready), .tensor_row(tensor_row),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .done(done)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic desc(input logic [7:0] a, input logic [3:0] m, input logic l);
    check("desc_txn_ready", txn_ready, 1);
    txn_valid = 1'b1;
    txn_alen = a;
    txn_col_mask = m;
    txn_is_last = l;
    step();
    txn_valid = 1'b0;
  endtask
  function automatic logic [127:0] rowk(input logic [31:0] k);
    return {k, k, k, k};
  endfunction
  initial begin
    rst = 1'b1; txn_valid = 1'b0; txn_alen = '0; txn_col_mask = '0; txn_is_last = 1'b0;
    tensor_valid = 1'b0; tensor_row = '0; wready = 1'b0;
    step();
    step();
    check("rst_txn_ready", txn_ready, 1);
    check("rst_tensor_ready", tensor_ready, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_wlast", wlast, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();
    // full mask, four streaming beats
    wready = 1'b1;
    desc(8'd3, 4'hF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tensor_valid = 1'b1;
      tensor_row = rowk(k);
      #1;
      check("t1_tensor_ready", tensor_ready, 1);
      step();
      check("t1_wvalid", wvalid, 1);
      check("t1_wdata", wdata, rowk(k));
      check("t1_wstrb", wstrb, 16'hFFFF);
      check("t1_wlast", wlast, k == 4);
    end
    tensor_valid = 1'b0;
    check("t1_idle", txn_ready, 1);
    step();
    check("t1_drain", wvalid, 0);
    check("t1_no_done", done, 0);
    // single beat, sparse mask
    desc(8'd0, 4'b0101, 1'b0);
    tensor_valid = 1'b1;
    tensor_row = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    tensor_valid = 1'b0;
    check("t2_wdata", wdata, {32'd0, 32'd3, 32'd0, 32'd1});
    check("t2_wstrb", wstrb, 16'h0F0F);
    check("t2_wlast", wlast, 1);
    check("t2_idle", txn_ready, 1);
    step();
    check("t2_drain", wvalid, 0);
    // backpressure on beat 2
    desc(8'd2, 4'hF, 1'b0);
    tensor_valid = 1'b1;
    tensor_row = rowk(32'h11);
    step();
    tensor_row = rowk(32'h22);
    step();
    wready = 1'b0;
    tensor_row = rowk(32'h33);
    repeat (5) begin
      step();
      check("t3_stall_tready", tensor_ready, 0);
      check("t3_stall_wvalid", wvalid, 1);
      check("t3_stall_wdata", wdata, rowk(32'h22));
      check("t3_stall_wstrb", wstrb, 16'hFFFF);
      check("t3_stall_wlast", wlast, 0);
    end
    wready = 1'b1;
    #1;
    check("t3_resume_tready", tensor_ready, 1);
    step();
    tensor_valid = 1'b0;
    check("t3_beat3_wdata", wdata, rowk(32'h33));
    check("t3_beat3_wlast", wlast, 1);
    step();
    check("t3_drain", wvalid, 0);
    // back-to-back descriptors, second one finishes the matrix
    desc(8'd0, 4'hF, 1'b0);
    tensor_valid = 1'b1;
    tensor_row = rowk(32'hA1);
    step();
    tensor_valid = 1'b0;
    check("t4_b1_wlast", wlast, 1);
    desc(8'd1, 4'hF, 1'b1);
    check("t4_gap_wvalid", wvalid, 0);
    check("t4_gap_done", done, 0);
    tensor_valid = 1'b1;
    tensor_row = rowk(32'hA2);
    step();
    check("t4_b2_wdata", wdata, rowk(32'hA2));
    check("t4_b2_wlast", wlast, 0);
    check("t4_b2_done", done, 0);
    tensor_row = rowk(32'hA3);
    step();
    tensor_valid = 1'b0;
    check("t4_b3_wdata", wdata, rowk(32'hA3));
    check("t4_b3_wlast", wlast, 1);
    check("t4_b3_done", done, 0);
    step();
    check("t4_done_pulse", done, 1);
    check("t4_drain", wvalid, 0);
    step();
    check("t4_done_clear", done, 0);
    // reset mid-burst with a beat waiting in the register
    wready = 1'b0;
    desc(8'd3, 4'hF, 1'b0);
    tensor_valid = 1'b1;
    tensor_row = rowk(32'h5);
    step();
    tensor_valid = 1'b0;
    check("t5_inflight", wvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_wvalid", wvalid, 0);
    check("t5_rst_wdata", wdata, 0);
    check("t5_rst_txn_ready", txn_ready, 1);
    wready = 1'b1;
    desc(8'd1, 4'b0011, 1'b1);
    tensor_valid = 1'b1;
    tensor_row = rowk(32'h6);
    step();
    check("t5_b1_wlast", wlast, 0);
    check("t5_b1_wdata", wdata, {64'd0, 32'h6, 32'h6});
    check("t5_b1_wstrb", wstrb, 16'h00FF);
    tensor_row = rowk(32'h7);
    step();
    tensor_valid = 1'b0;
    check("t5_b2_wlast", wlast, 1);
    step();
    check("t5_done", done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
